// File: rtl/mod_n_down_chain.sv
// mod_n_down_chain: cascadable BCD down-counting timer chain.
// Each digit has its own modulus (2..10); digit 0 is least significant.
// Digits borrow from one another like a clock face (e.g. MM:SS with a
// mod-6 tens-of-seconds digit), never through a binary carry.
// WRAP=0 holds at all-zero; WRAP=1 rolls all-zero over to all-(MOD-1).
// done pulses for one cycle when a decrement lands on all-zero.
// bo (borrow-out) feeds the enable of a further, more significant chain.
module mod_n_down_chain #(
    parameter int                      NUM_DIGITS = 4,
    parameter logic [4*NUM_DIGITS-1:0] MODULI     = 16'hAA6A,
    parameter bit                      WRAP       = 1'b0
) (
    input  logic                      clock,
    input  logic                      clear,
    input  logic                      loadn,
    input  logic                      en,
    input  logic [4*NUM_DIGITS-1:0]   data,
    output logic [4*NUM_DIGITS-1:0]   count,
    output logic                      zero,
    output logic                      done,
    output logic                      bo
);

    localparam int W = 4 * NUM_DIGITS;

    // Reject moduli outside 2..10 when the chain is elaborated.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_mod_check
        if ((MODULI[4*g +: 4] < 4'd2) || (MODULI[4*g +: 4] > 4'd10)) begin : g_bad
            $error("mod_n_down_chain: digit %0d has illegal modulus %0d",
                   g, MODULI[4*g +: 4]);
        end
    end

    logic [W-1:0] count_q, count_d;
    logic         done_q,  done_d;
    logic [W-1:0] load_val;
    logic [W-1:0] dec_val;
    logic         borrow;
    logic         count_is_zero;

    assign count_is_zero = (count_q == '0);

    // Per-digit clamped load value and the borrow-rippled decrement value.
    // A digit steps only while every lower digit is 0; a stepping digit at 0
    // reloads MOD-1. From all-zero this naturally produces all-(MOD-1).
    always_comb begin
        load_val = '0;
        dec_val  = '0;
        borrow   = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (data[4*k +: 4] >= MODULI[4*k +: 4]) begin
                load_val[4*k +: 4] = MODULI[4*k +: 4] - 4'd1;
            end else begin
                load_val[4*k +: 4] = data[4*k +: 4];
            end

            if (borrow) begin
                if (count_q[4*k +: 4] == 4'd0) begin
                    dec_val[4*k +: 4] = MODULI[4*k +: 4] - 4'd1;
                end else begin
                    dec_val[4*k +: 4] = count_q[4*k +: 4] - 4'd1;
                end
            end else begin
                dec_val[4*k +: 4] = count_q[4*k +: 4];
            end

            borrow = borrow & (count_q[4*k +: 4] == 4'd0);
        end
    end

    // Next-state selection: load beats decrement beats hold (clear is in the flop).
    // done only fires when a decrement leaves a nonzero count at zero.
    always_comb begin
        count_d = count_q;
        done_d  = 1'b0;
        if (!loadn) begin
            count_d = load_val;
        end else if (en) begin
            if (!count_is_zero) begin
                count_d = dec_val;
                done_d  = (dec_val == '0);
            end else if (WRAP) begin
                count_d = dec_val;
            end
        end
    end

    // Count and done registers with synchronous clear.
    always_ff @(posedge clock) begin
        if (clear) begin
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign count = count_q;
    assign zero  = count_is_zero;
    assign done  = done_q;
    assign bo    = en & loadn & ~clear & count_is_zero;

endmodule

// File: tb/tb_mod_n_down_chain.sv
// Directed bench for mod_n_down_chain: a hold-at-zero instance and a wrap
// instance share one set of inputs; each step checks hand-computed values.
module tb_mod_n_down_chain;

    logic        clock;
    logic        clear;
    logic        loadn;
    logic        en;
    logic [15:0] data;

    logic [15:0] count_h, count_w;
    logic        zero_h, zero_w;
    logic        done_h, done_w;
    logic        bo_h, bo_w;

    int checks = 0;
    int errors = 0;

    mod_n_down_chain #(.NUM_DIGITS(4), .MODULI(16'hAA6A), .WRAP(1'b0)) dut_hold (
        .clock (clock),
        .clear (clear),
        .loadn (loadn),
        .en    (en),
        .data  (data),
        .count (count_h),
        .zero  (zero_h),
        .done  (done_h),
        .bo    (bo_h)
    );

    mod_n_down_chain #(.NUM_DIGITS(4), .MODULI(16'hAA6A), .WRAP(1'b1)) dut_wrap (
        .clock (clock),
        .clear (clear),
        .loadn (loadn),
        .en    (en),
        .data  (data),
        .count (count_w),
        .zero  (zero_w),
        .done  (done_w),
        .bo    (bo_w)
    );

    // Clock generation
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge and settle before sampling.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        clear = 1'b1;
        loadn = 1'b0;
        en    = 1'b1;
        data  = 16'h1234;

        // 1: clear beats load and enable
        tick();
        tick();
        check("rst_count", count_h, 16'h0000);
        check("rst_zero",  {15'd0, zero_h}, 16'd1);
        check("rst_done",  {15'd0, done_h}, 16'd0);
        check("rst_bo",    {15'd0, bo_h},   16'd0);
        check("rst_count_w", count_w, 16'h0000);

        // 2: 01:30 countdown over 90 seconds
        clear = 1'b0;
        loadn = 1'b0;
        en    = 1'b0;
        data  = 16'h0130;
        tick();
        check("ld0130_count", count_h, 16'h0130);
        check("ld0130_done",  {15'd0, done_h}, 16'd0);
        loadn = 1'b1;
        en    = 1'b1;
        tick();
        check("e1_count", count_h, 16'h0129);
        repeat (29) tick();
        check("e30_count", count_h, 16'h0100);
        tick();
        check("e31_count", count_h, 16'h0059);
        repeat (58) tick();
        check("e89_count", count_h, 16'h0001);
        check("e89_done",  {15'd0, done_h}, 16'd0);
        check("e89_bo",    {15'd0, bo_h},   16'd0);
        tick();
        check("e90_count", count_h, 16'h0000);
        check("e90_done",  {15'd0, done_h}, 16'd1);
        check("e90_zero",  {15'd0, zero_h}, 16'd1);
        check("e90_bo",    {15'd0, bo_h},   16'd1);
        check("e90_done_w", {15'd0, done_w}, 16'd1);
        tick();
        check("e91_count", count_h, 16'h0000);
        check("e91_done",  {15'd0, done_h}, 16'd0);
        check("e91_bo",    {15'd0, bo_h},   16'd1);
        check("e91_count_w", count_w, 16'h9959);

        // 3: borrow through the mod-6 digit
        loadn = 1'b0;
        data  = 16'h0100;
        tick();
        loadn = 1'b1;
        tick();
        check("b100_count", count_h, 16'h0059);
        check("b100_zero",  {15'd0, zero_h}, 16'd0);
        check("b100_done",  {15'd0, done_h}, 16'd0);

        // 4: clamped load, load beats enable
        loadn = 1'b0;
        data  = 16'h9F7C;
        tick();
        check("clamp_count",   count_h, 16'h9959);
        check("clamp_count_w", count_w, 16'h9959);
        check("clamp_done",    {15'd0, done_h}, 16'd0);

        // 5: wrap from zero, then done on the wrap instance
        data = 16'h0000;
        tick();
        check("ld0_count_w", count_w, 16'h0000);
        check("ld0_done_w",  {15'd0, done_w}, 16'd0);
        loadn = 1'b1;
        #1;
        check("wrap_bo_w", {15'd0, bo_w}, 16'd1);
        check("hold_bo_h", {15'd0, bo_h}, 16'd1);
        tick();
        check("wrap_count_w", count_w, 16'h9959);
        check("wrap_done_w",  {15'd0, done_w}, 16'd0);
        check("hold_count_h", count_h, 16'h0000);
        check("hold_done_h",  {15'd0, done_h}, 16'd0);
        loadn = 1'b0;
        data  = 16'h0001;
        tick();
        loadn = 1'b1;
        tick();
        check("one_count_w", count_w, 16'h0000);
        check("one_done_w",  {15'd0, done_w}, 16'd1);
        check("one_done_h",  {15'd0, done_h}, 16'd1);

        // 6: load mid-count, hold with en=0, then clear
        loadn = 1'b0;
        data  = 16'h0042;
        tick();
        check("mid_count", count_h, 16'h0042);
        data = 16'h0010;
        tick();
        check("mid_load_count", count_h, 16'h0010);
        loadn = 1'b1;
        en    = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_en0_count", count_h, 16'h0010);
            check("hold_en0_done",  {15'd0, done_h}, 16'd0);
        end
        check("hold_en0_bo", {15'd0, bo_h}, 16'd0);
        en    = 1'b1;
        clear = 1'b1;
        #1;
        check("clr_bo_live", {15'd0, bo_h}, 16'd0);
        tick();
        check("clr_count", count_h, 16'h0000);
        check("clr_done",  {15'd0, done_h}, 16'd0);
        check("clr_zero",  {15'd0, zero_h}, 16'd1);
        check("clr_bo",    {15'd0, bo_h},   16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
